// File: rtl/or2_gate_pkg.sv
// Shared defaults for the or2_gate slice: operand width and activity-counter width.
// Imported by the interface, the counter and the top so the defaults stay in one place.
package or2_gate_pkg;

    localparam int OR2_WIDTH_DEF   = 1;
    localparam int OR2_COUNT_W_DEF = 16;

endpackage

// File: rtl/or2_gate_if.sv
// Signal bundle for one or2_gate instance: operands, combinational and registered results,
// and the activity count. The master drives operands; the slave (the gate) drives results.
interface or2_gate_if
    import or2_gate_pkg::*;
#(
    parameter int WIDTH   = OR2_WIDTH_DEF,
    parameter int COUNT_W = OR2_COUNT_W_DEF
);

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   out;
    logic [WIDTH-1:0]   out_q;
    logic [COUNT_W-1:0] hit_cnt;

    modport master (
        output a,
        output b,
        input  out,
        input  out_q,
        input  hit_cnt
    );

    modport slave (
        input  a,
        input  b,
        output out,
        output out_q,
        output hit_cnt
    );

endinterface

// File: rtl/or2_gate_sat_counter.sv
// Saturating up-counter: advances by one on each enabled rising edge and holds at all-ones.
// Reset is asynchronous and active-high and clears the count to zero.
module sat_counter
    import or2_gate_pkg::*;
#(
    parameter int COUNT_W = OR2_COUNT_W_DEF
) (
    input  logic               enable,
    input  logic               clk,
    input  logic               rst,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/or2_gate.sv
// Bitwise two-input OR with a registered copy of the result and a saturating count of
// cycles in which that registered copy was non-zero.
module or2_gate
    import or2_gate_pkg::*;
#(
    parameter int WIDTH   = OR2_WIDTH_DEF,
    parameter int COUNT_W = OR2_COUNT_W_DEF
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   out,
    input  logic               clk,
    input  logic               rst,
    output logic [WIDTH-1:0]   out_q,
    output logic [COUNT_W-1:0] hit_cnt
);

    // Primary path: purely combinational, independent of clk and rst.
    assign out = a | b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= a | b;
        end
    end

    // Counts on the current registered value, so hit_cnt trails out_q by one edge.
    sat_counter #(
        .COUNT_W (COUNT_W)
    ) u_hit_cnt (
        .enable (|out_q),
        .clk    (clk),
        .rst    (rst),
        .count  (hit_cnt)
    );

endmodule

// File: tb/tb_or2_gate.sv
// Self-checking bench for or2_gate: combinational truth table, registered copy,
// asynchronous reset, activity counting and saturation, against a behavioural model.
module tb_or2_gate;

    int tests_run    = 0;
    int tests_failed = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 instance with its clock and reset tied off (never toggled).
    logic        a1 = 1'b0;
    logic        b1 = 1'b0;
    logic        out1;
    logic        outq1;
    logic [15:0] hit1;
    logic        clk_nc = 1'b0;
    logic        rst_nc = 1'b0;
    logic        bx;

    or2_gate #(.WIDTH(1), .COUNT_W(16)) dut1 (
        .a(a1), .b(b1), .out(out1), .clk(clk_nc), .rst(rst_nc),
        .out_q(outq1), .hit_cnt(hit1)
    );

    // WIDTH=8 instance driven through the interface bundle.
    or2_gate_if #(.WIDTH(8), .COUNT_W(16)) bus8 ();

    or2_gate #(.WIDTH(8), .COUNT_W(16)) dut8 (
        .a(bus8.a), .b(bus8.b), .out(bus8.out), .clk(clk), .rst(rst),
        .out_q(bus8.out_q), .hit_cnt(bus8.hit_cnt)
    );

    // WIDTH=8, COUNT_W=2 instance for saturation.
    logic [7:0] a2 = 8'h00;
    logic [7:0] b2 = 8'h00;
    logic [7:0] out2;
    logic [7:0] outq2;
    logic [1:0] hit2;

    or2_gate #(.WIDTH(8), .COUNT_W(2)) dut2 (
        .a(a2), .b(b2), .out(out2), .clk(clk), .rst(rst),
        .out_q(outq2), .hit_cnt(hit2)
    );

    // Behavioural model: last captured OR value and number of counted edges, capped.
    logic [7:0] m8_q  = 8'h00;
    int         m8_cnt = 0;
    logic [7:0] m2_q  = 8'h00;
    int         m2_cnt = 0;
    localparam int MAX8 = 65535;
    localparam int MAX2 = 3;

    task automatic model_clear();
        m8_q = 8'h00; m8_cnt = 0;
        m2_q = 8'h00; m2_cnt = 0;
    endtask

    // Advance one rising edge and update the model, then settle before sampling.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (m8_q != 8'h00) m8_cnt = (m8_cnt + 1 > MAX8) ? MAX8 : m8_cnt + 1;
            if (m2_q != 8'h00) m2_cnt = (m2_cnt + 1 > MAX2) ? MAX2 : m2_cnt + 1;
            m8_q = bus8.a | bus8.b;
            m2_q = a2 | b2;
        end
        #1;
    endtask

    task automatic test_reset();
        bus8.a = 8'h00; bus8.b = 8'h00;
        #1 rst = 1'b1;
        model_clear();
        #1;
        tests_run++;
        if (bus8.out_q !== 8'h00) begin
            tests_failed++; $display("FAIL reset_outq8: got %0h expected 0", bus8.out_q);
        end
        tests_run++;
        if (bus8.hit_cnt !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_hit8: got %0h expected 0", bus8.hit_cnt);
        end
        tests_run++;
        if (hit2 !== 2'b00) begin
            tests_failed++; $display("FAIL reset_hit2: got %0h expected 0", hit2);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_comb_exhaustive();
        logic exp_tab [4];
        logic [1:0] v;
        exp_tab = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            v  = 2'(i);
            a1 = v[1];
            b1 = v[0];
            #5;
            tests_run++;
            if (out1 !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL comb_w1 a=%0b b=%0b: got %0b expected %0b", a1, b1, out1, exp_tab[i]);
            end
        end
    endtask

    task automatic test_pattern();
        @(negedge clk);
        bus8.a = 8'hA0; bus8.b = 8'h05;
        #1;
        tests_run++;
        if (bus8.out !== 8'hA5) begin
            tests_failed++; $display("FAIL pattern_out: got %0h expected a5", bus8.out);
        end
        step();
        tests_run++;
        if (bus8.out_q !== 8'hA5) begin
            tests_failed++; $display("FAIL pattern_outq: got %0h expected a5", bus8.out_q);
        end
    endtask

    task automatic test_random();
        logic [7:0] ra, rb;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ((i % 7) == 3) begin ra = 8'h00; rb = 8'h00; end
            bus8.a = ra; bus8.b = rb;
            #1;
            tests_run++;
            if (bus8.out !== (ra | rb)) begin
                tests_failed++; $display("FAIL rand_out[%0d]: got %0h expected %0h", i, bus8.out, ra | rb);
            end
            step();
            tests_run++;
            if (bus8.out_q !== m8_q) begin
                tests_failed++; $display("FAIL rand_outq[%0d]: got %0h expected %0h", i, bus8.out_q, m8_q);
            end
            tests_run++;
            if (int'(bus8.hit_cnt) != m8_cnt) begin
                tests_failed++; $display("FAIL rand_hit[%0d]: got %0d expected %0d", i, bus8.hit_cnt, m8_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus8.a = 8'hF0; bus8.b = 8'h0F;
        step();
        tests_run++;
        if (bus8.out_q !== 8'hFF) begin
            tests_failed++; $display("FAIL areset_pre_outq: got %0h expected ff", bus8.out_q);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        model_clear();
        #1;
        tests_run++;
        if (bus8.out_q !== 8'h00) begin
            tests_failed++; $display("FAIL areset_outq: got %0h expected 0", bus8.out_q);
        end
        tests_run++;
        if (bus8.hit_cnt !== 16'h0000) begin
            tests_failed++; $display("FAIL areset_hit: got %0h expected 0", bus8.hit_cnt);
        end
        tests_run++;
        if (bus8.out !== 8'hFF) begin
            tests_failed++; $display("FAIL areset_out: got %0h expected ff", bus8.out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_count();
        bus8.a = 8'h01; bus8.b = 8'h00;
        for (int i = 0; i < 10; i++) step();
        tests_run++;
        if (bus8.hit_cnt !== 16'd9) begin
            tests_failed++; $display("FAIL count_10_edges: got %0d expected 9", bus8.hit_cnt);
        end
        tests_run++;
        if (int'(bus8.hit_cnt) != m8_cnt) begin
            tests_failed++; $display("FAIL count_model: got %0d expected %0d", bus8.hit_cnt, m8_cnt);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        a2 = 8'h3C; b2 = 8'h00;
        for (int i = 0; i < 6; i++) begin
            step();
            tests_run++;
            if (int'(hit2) != m2_cnt) begin
                tests_failed++; $display("FAIL sat_hit[%0d]: got %0d expected %0d", i, hit2, m2_cnt);
            end
        end
        tests_run++;
        if (hit2 !== 2'd3) begin
            tests_failed++; $display("FAIL sat_final: got %0d expected 3", hit2);
        end
        @(negedge clk);
        a2 = 8'h00;
        step();
        step();
        tests_run++;
        if (hit2 !== 2'd3) begin
            tests_failed++; $display("FAIL sat_hold: got %0d expected 3", hit2);
        end
    endtask

    task automatic test_xprop();
        bx = 1'bx;
        a1 = 1'b1; b1 = bx;
        #5;
        tests_run++;
        if (out1 !== 1'b1) begin
            tests_failed++; $display("FAIL xprop_one: got %0b expected 1", out1);
        end
        a1 = 1'b0; b1 = bx;
        #5;
        tests_run++;
        if (out1 !== (1'b0 | bx)) begin
            tests_failed++; $display("FAIL xprop_zero: got %0b expected %0b", out1, 1'b0 | bx);
        end
    endtask

    initial begin
        test_reset();
        test_comb_exhaustive();
        test_pattern();
        test_random();
        test_async_reset();
        test_count();
        test_saturation();
        test_xprop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
